// File: rtl/lcd_req_arbiter_if.sv
//==============================================================================
// Module  : lcd_req_arbiter_if
// Purpose : Bundles the requester-side and LCD-controller-side signals of
//           lcd_req_arbiter.
//           slave  modport : the arbiter itself
//           master modport : whatever drives the requests and models the
//                            LCD controller (requesters + controller)
// Signals : req[NREQ]        level request per requester
//           req_bus[NREQ*10] per-requester command word {rs, rw, data[7:0]}
//           ack[NREQ]        one-hot, one-cycle grant pulse
//           lcd_busy         busy from the LCD controller
//           lcd_enable       command-valid to the LCD controller
//           lcd_bus[10]      latched command word
//           grant_id[3]      current / last winner index
//           arb_busy         arbiter not in IDLE
//           err              one-cycle timeout pulse
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface lcd_req_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*10-1:0] req_bus;
    logic [NREQ-1:0]    ack;
    logic               lcd_busy;
    logic               lcd_enable;
    logic [9:0]         lcd_bus;
    logic [2:0]         grant_id;
    logic               arb_busy;
    logic               err;

    modport master (
        output req, req_bus, lcd_busy,
        input  ack, lcd_enable, lcd_bus, grant_id, arb_busy, err
    );

    modport slave (
        input  req, req_bus, lcd_busy,
        output ack, lcd_enable, lcd_bus, grant_id, arb_busy, err
    );
endinterface

`default_nettype wire

// File: rtl/lcd_req_arbiter.sv
//==============================================================================
// Module  : lcd_req_arbiter
// Purpose : Round-robin arbiter sharing one HD44780-style LCD controller
//           between NREQ command sources. The winning 10-bit command word is
//           latched and presented with lcd_enable until the controller raises
//           busy; the arbiter then waits for busy to fall before the next
//           grant. All outputs are registered.
// Ports   : clk        - clock, all state updates on the rising edge
//           rst        - asynchronous, active-high reset
//           arb        - lcd_req_arbiter_if.slave (requests, acks, LCD side)
// Params  : NREQ       - number of requesters, 2..8; must match arb's NREQ
//           TIMEOUT    - cycles allowed in ISSUE without busy (timeout build)
// Macros  : LCD_ARB_TIMEOUT_EN - when defined, an ISSUE phase that never sees
//           busy is abandoned after TIMEOUT cycles with a one-cycle err pulse.
//           When undefined, ISSUE waits forever and err is tied low.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module lcd_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    lcd_req_arbiter_if.slave arb
);

    localparam int         WORD_W = 10;
    localparam logic [3:0] c_NREQ = 4'(NREQ);

    generate
        if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
            $error("lcd_req_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    //--------------------------------------------------------------------------
    // Registered state and outputs
    //--------------------------------------------------------------------------
    state_t              r_state;
    logic [2:0]          r_ptr;
    logic                r_lcd_enable;
    logic [WORD_W-1:0]   r_lcd_bus;
    logic [NREQ-1:0]     r_ack;
    logic [2:0]          r_grant_id;
    logic                r_arb_busy;

    state_t              w_state_nxt;
    logic [2:0]          w_ptr_nxt;
    logic                w_lcd_enable_nxt;
    logic [WORD_W-1:0]   w_lcd_bus_nxt;
    logic [NREQ-1:0]     w_ack_nxt;
    logic [2:0]          w_grant_id_nxt;
    logic                w_arb_busy_nxt;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]    r_tmo_cnt;
    logic [CNT_W-1:0]    w_tmo_cnt_nxt;
    logic                r_err;
    logic                w_err_nxt;
`endif

    //--------------------------------------------------------------------------
    // Round-robin winner search
    //--------------------------------------------------------------------------
    // The request vector is rotated so that bit 0 corresponds to requester
    // r_ptr; the lowest set bit of the rotated vector is then the offset of
    // the winner from the pointer. Doubling the vector (minus its top bit,
    // which no rotation reaches) makes every rotation a plain slice.
    logic [2*NREQ-2:0]   w_req_dbl;
    logic [NREQ-1:0]     w_req_rot;
    logic                w_any_req;
    logic [2:0]          w_offset;
    logic [3:0]          w_sum;
    logic [3:0]          w_sum_inc;
    logic [2:0]          w_winner;
    logic [2:0]          w_ptr_adv;
    logic [WORD_W-1:0]   w_word;
    logic [NREQ-1:0]     w_onehot;

    assign w_req_dbl = {arb.req[NREQ-2:0], arb.req};
    assign w_any_req = |arb.req;

    always_comb begin : p_rotate
        w_req_rot = arb.req;
        for (int p = 1; p < NREQ; p++) begin
            if (r_ptr == 3'(p)) begin
                w_req_rot = w_req_dbl[p +: NREQ];
            end
        end
    end

    // Scan from the top down so the lowest set bit wins.
    always_comb begin : p_first_set
        w_offset = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_offset = 3'(k);
            end
        end
    end

    // Winner index and the advanced pointer, both reduced mod NREQ. Both
    // operands are below NREQ, so one conditional subtract suffices.
    always_comb begin : p_winner
        w_sum = {1'b0, r_ptr} + {1'b0, w_offset};
        if (w_sum >= c_NREQ) begin
            w_sum = w_sum - c_NREQ;
        end
        w_winner  = w_sum[2:0];
        w_sum_inc = {1'b0, w_winner} + 4'd1;
        if (w_sum_inc >= c_NREQ) begin
            w_sum_inc = 4'd0;
        end
        w_ptr_adv = w_sum_inc[2:0];
    end

    // Command word of the winner and its one-hot ack pattern.
    always_comb begin : p_select
        w_word   = '0;
        w_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_winner == 3'(k)) begin
                w_word      = arb.req_bus[WORD_W*k +: WORD_W];
                w_onehot[k] = 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Next-state / next-output logic
    //--------------------------------------------------------------------------
    always_comb begin : p_next
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_lcd_enable_nxt = 1'b0;
        w_lcd_bus_nxt    = r_lcd_bus;
        w_ack_nxt        = '0;
        w_grant_id_nxt   = r_grant_id;
`ifdef LCD_ARB_TIMEOUT_EN
        w_err_nxt        = 1'b0;
        w_tmo_cnt_nxt    = '0;
`endif

        unique case (r_state)
            S_IDLE: begin
                // A busy controller (e.g. still initialising) blocks grants.
                if (!arb.lcd_busy && w_any_req) begin
                    w_state_nxt      = S_ISSUE;
                    w_lcd_enable_nxt = 1'b1;
                    w_lcd_bus_nxt    = w_word;
                    w_grant_id_nxt   = w_winner;
                    w_ack_nxt        = w_onehot;
                    w_ptr_nxt        = w_ptr_adv;
                end
            end

            S_ISSUE: begin
                if (arb.lcd_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
`ifdef LCD_ARB_TIMEOUT_EN
                // The counter already holds the number of ISSUE edges seen,
                // so the TIMEOUT-th edge without busy abandons the word and
                // lcd_enable has been high for exactly TIMEOUT cycles.
                else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
                else begin
                    w_lcd_enable_nxt = 1'b1;
                    w_tmo_cnt_nxt    = r_tmo_cnt + CNT_W'(1);
                end
`else
                else begin
                    w_lcd_enable_nxt = 1'b1;
                end
`endif
            end

            S_WAIT_DONE: begin
                if (!arb.lcd_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_arb_busy_nxt = (w_state_nxt != S_IDLE);
    end

    //--------------------------------------------------------------------------
    // State and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin : p_regs
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= 3'd0;
            r_lcd_enable <= 1'b0;
            r_lcd_bus    <= '0;
            r_ack        <= '0;
            r_grant_id   <= 3'd0;
            r_arb_busy   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_lcd_enable <= w_lcd_enable_nxt;
            r_lcd_bus    <= w_lcd_bus_nxt;
            r_ack        <= w_ack_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_arb_busy   <= w_arb_busy_nxt;
        end
    end

`ifdef LCD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin : p_tmo_regs
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign arb.err = r_err;
`else
    assign arb.err = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign arb.ack        = r_ack;
    assign arb.lcd_enable = r_lcd_enable;
    assign arb.lcd_bus    = r_lcd_bus;
    assign arb.grant_id   = r_grant_id;
    assign arb.arb_busy   = r_arb_busy;

endmodule

`default_nettype wire

// File: tb/tb_lcd_req_arbiter.sv
//==============================================================================
// Module  : tb_lcd_req_arbiter
// Purpose : Directed self-checking bench for lcd_req_arbiter (NREQ=4,
//           TIMEOUT=16). Includes a small LCD-controller model that raises
//           busy on the edge after it first sees lcd_enable and holds it for
//           a programmable number of cycles.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_req_arbiter;

    localparam int NREQ = 4;

    logic clk;
    logic rst;

    lcd_req_arbiter_if #(.NREQ(NREQ)) bus ();

    lcd_req_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // controller model state
    bit   model_on;
    int   busy_len;
    int   ctrl_cnt;
    logic en_d1;
    logic en_d2;
    bit   drop_on_ack;

    // observation log
    int              n_grants;
    int              en_cycles;
    int              err_cnt;
    int              idle_cnt;
    int              ack_bad;
    logic [2:0]      g_id[$];
    logic [9:0]      g_bus[$];
    logic [NREQ-1:0] g_ack[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic clear_logs();
        n_grants  = 0;
        en_cycles = 0;
        err_cnt   = 0;
        idle_cnt  = 0;
        ack_bad   = 0;
        g_id.delete();
        g_bus.delete();
        g_ack.delete();
    endtask

    task automatic set_word(input int idx, input logic [9:0] w);
        bus.req_bus[10*idx +: 10] = w;
    endtask

    // One clock: wait for the edge, then act as the controller and log.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (model_on) begin
            if (ctrl_cnt > 0) begin
                ctrl_cnt--;
                if (ctrl_cnt == 0) bus.lcd_busy = 1'b0;
            end else if (en_d1 && !en_d2) begin
                bus.lcd_busy = 1'b1;
                ctrl_cnt     = busy_len;
            end
        end
        en_d2 = en_d1;
        en_d1 = bus.lcd_enable;

        if (bus.ack != '0) begin
            g_id.push_back(bus.grant_id);
            g_bus.push_back(bus.lcd_bus);
            g_ack.push_back(bus.ack);
            if ($countones(bus.ack) != 1) ack_bad++;
            n_grants++;
            if (drop_on_ack) bus.req = bus.req & ~bus.ack;
        end
        if (bus.lcd_enable) en_cycles++;
        if (bus.err) err_cnt++;
        if (n_grants > 0 && !bus.arb_busy) idle_cnt++;
    endtask

    task automatic reset_dut();
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_bus  = '0;
        bus.lcd_busy = 1'b0;
        model_on     = 1'b0;
        busy_len     = 1;
        ctrl_cnt     = 0;
        en_d1        = 1'b0;
        en_d2        = 1'b0;
        drop_on_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    //--------------------------------------------------------------------------
    task automatic test_reset();
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_bus  = '0;
        bus.lcd_busy = 1'b0;
        model_on     = 1'b0;
        ctrl_cnt     = 0;
        en_d1        = 1'b0;
        en_d2        = 1'b0;
        drop_on_ack  = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({bus.lcd_enable, bus.ack, bus.err, bus.arb_busy} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got en/ack/err/busy=%b expected 0000000",
                     {bus.lcd_enable, bus.ack, bus.err, bus.arb_busy});
        end
        tests_run++;
        if ({bus.grant_id, bus.lcd_bus} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got grant_id=%0d lcd_bus=%h expected 0/000",
                     bus.grant_id, bus.lcd_bus);
        end

        rst = 1'b0;
        clear_logs();
        set_word(1, 10'h155);
        bus.req = 4'b0010;
        cycle();
        tests_run++;
        if (bus.ack !== 4'b0010 || bus.grant_id !== 3'd1 || bus.lcd_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre_grant: got ack=%b id=%0d en=%b expected 0010/1/1",
                     bus.ack, bus.grant_id, bus.lcd_enable);
        end
        cycle();
        cycle();

        // asynchronous reset in the middle of a clock period, mid-ISSUE
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.lcd_enable, bus.ack, bus.err, bus.arb_busy} !== 7'd0 || bus.grant_id !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got en=%b ack=%b err=%b busy=%b id=%0d expected all 0",
                     bus.lcd_enable, bus.ack, bus.err, bus.arb_busy, bus.grant_id);
        end

        @(posedge clk);
        #1;
        rst   = 1'b0;
        en_d1 = 1'b0;
        en_d2 = 1'b0;
        clear_logs();
        repeat (3) cycle();
        tests_run++;
        if (n_grants != 0 || en_cycles != 0) begin
            tests_failed++;
            $display("FAIL reset_no_reissue: got grants=%0d en_cycles=%0d expected 0/0",
                     n_grants, en_cycles);
        end

        set_word(0, 10'h0AA);
        set_word(3, 10'h3FF);
        bus.req = 4'b1001;
        cycle();
        tests_run++;
        if (bus.ack !== 4'b0001 || bus.grant_id !== 3'd0 || bus.lcd_bus !== 10'h0AA) begin
            tests_failed++;
            $display("FAIL reset_ptr_zero: got ack=%b id=%0d bus=%h expected 0001/0/0aa",
                     bus.ack, bus.grant_id, bus.lcd_bus);
        end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_init_block();
        reset_dut();
        bus.lcd_busy = 1'b1;
        set_word(0, 10'h230);
        set_word(2, 10'h001);
        bus.req = 4'b0101;
        repeat (100) cycle();
        tests_run++;
        if (n_grants != 0 || en_cycles != 0 || bus.arb_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_block: got grants=%0d en_cycles=%0d arb_busy=%b expected 0/0/0",
                     n_grants, en_cycles, bus.arb_busy);
        end
        bus.lcd_busy = 1'b0;
        cycle();
        tests_run++;
        if (bus.ack !== 4'b0001 || bus.lcd_bus !== 10'h230 || bus.lcd_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL init_release: got ack=%b bus=%h en=%b expected 0001/230/1",
                     bus.ack, bus.lcd_bus, bus.lcd_enable);
        end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_round_robin();
        logic [2:0] exp_id[5];
        logic [9:0] exp_bus[5];
        exp_id  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        exp_bus = '{10'h230, 10'h00C, 10'h001, 10'h006, 10'h230};

        reset_dut();
        set_word(0, 10'h230);
        set_word(1, 10'h00C);
        set_word(2, 10'h001);
        set_word(3, 10'h006);
        bus.req  = 4'b1111;
        model_on = 1'b1;
        busy_len = 20;
        for (int c = 0; c < 300 && n_grants < 5; c++) cycle();

        tests_run++;
        if (n_grants != 5) begin
            tests_failed++;
            $display("FAIL rr_grant_count: got %0d grants within 300 cycles expected 5", n_grants);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (g_id[i] !== exp_id[i] || g_bus[i] !== exp_bus[i]) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got id=%0d bus=%h expected id=%0d bus=%h",
                         i, g_id[i], g_bus[i], exp_id[i], exp_bus[i]);
            end
        end
        tests_run++;
        if (ack_bad != 0) begin
            tests_failed++;
            $display("FAIL rr_onehot: got %0d non-one-hot acks expected 0", ack_bad);
        end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_handshake();
        int   busy_fall_s;
        int   idle_s;
        logic pb;
        busy_fall_s = -1;
        idle_s      = -1;

        reset_dut();
        set_word(2, 10'h241);
        bus.req     = 4'b0100;
        drop_on_ack = 1'b1;
        model_on    = 1'b1;
        busy_len    = 3;
        for (int s = 1; s <= 20; s++) begin
            pb = bus.lcd_busy;
            cycle();
            if (pb && !bus.lcd_busy && busy_fall_s < 0) busy_fall_s = s;
            if (n_grants > 0 && !bus.arb_busy && idle_s < 0) idle_s = s;
        end

        tests_run++;
        if (en_cycles != 2) begin
            tests_failed++;
            $display("FAIL hs_enable_len: got %0d cycles expected 2", en_cycles);
        end
        tests_run++;
        if (n_grants != 1 || g_id[0] !== 3'd2 || g_bus[0] !== 10'h241 || g_ack[0] !== 4'b0100) begin
            tests_failed++;
            $display("FAIL hs_grant: got grants=%0d id=%0d bus=%h ack=%b expected 1/2/241/0100",
                     n_grants, g_id[0], g_bus[0], g_ack[0]);
        end
        tests_run++;
        if (busy_fall_s != 5 || idle_s != 6) begin
            tests_failed++;
            $display("FAIL hs_arb_busy: got busy_fall=%0d arb_idle=%0d expected 5/6",
                     busy_fall_s, idle_s);
        end
        tests_run++;
        if (bus.lcd_bus !== 10'h241) begin
            tests_failed++;
            $display("FAIL hs_bus_hold: got %h expected 241", bus.lcd_bus);
        end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_back_to_back();
        reset_dut();
        set_word(0, 10'h0A0);
        set_word(1, 10'h0B1);
        bus.req  = 4'b0011;
        model_on = 1'b1;
        busy_len = 2;
        for (int c = 0; c < 200 && n_grants < 4; c++) cycle();

        tests_run++;
        if (n_grants != 4) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d grants within 200 cycles expected 4", n_grants);
        end
        tests_run++;
        if (g_id[0] !== 3'd0 || g_id[1] !== 3'd1 || g_id[2] !== 3'd0 || g_id[3] !== 3'd1) begin
            tests_failed++;
            $display("FAIL b2b_order: got %0d,%0d,%0d,%0d expected 0,1,0,1",
                     g_id[0], g_id[1], g_id[2], g_id[3]);
        end
        tests_run++;
        if (idle_cnt != 3) begin
            tests_failed++;
            $display("FAIL b2b_idle_gap: got %0d idle cycles expected 3", idle_cnt);
        end
    endtask

    //--------------------------------------------------------------------------
`ifdef LCD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        reset_dut();
        set_word(1, 10'h2AA);
        set_word(2, 10'h0C5);
        bus.req     = 4'b0110;
        drop_on_ack = 1'b1;
        repeat (17) cycle();
        tests_run++;
        if (en_cycles != 16 || err_cnt != 1 || bus.arb_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_abort: got en_cycles=%0d err=%0d arb_busy=%b expected 16/1/0",
                     en_cycles, err_cnt, bus.arb_busy);
        end
        cycle();
        tests_run++;
        if (bus.ack !== 4'b0100 || bus.grant_id !== 3'd2 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_next_grant: got ack=%b id=%0d err=%b expected 0100/2/0",
                     bus.ack, bus.grant_id, bus.err);
        end
    endtask
`else
    task automatic test_no_timeout();
        reset_dut();
        set_word(1, 10'h2AA);
        bus.req     = 4'b0010;
        drop_on_ack = 1'b1;
        cycle();
        tests_run++;
        if (bus.ack !== 4'b0010 || bus.lcd_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL notmo_grant: got ack=%b en=%b expected 0010/1", bus.ack, bus.lcd_enable);
        end
        en_cycles = 0;
        repeat (1000) cycle();
        tests_run++;
        if (en_cycles != 1000 || err_cnt != 0 || bus.arb_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL notmo_hold: got en_cycles=%0d err=%0d arb_busy=%b expected 1000/0/1",
                     en_cycles, err_cnt, bus.arb_busy);
        end
    endtask
`endif

    //--------------------------------------------------------------------------
    initial begin
        test_reset();
        test_init_block();
        test_round_robin();
        test_handshake();
        test_back_to_back();
`ifdef LCD_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
